// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : DEC <-> hazard scoreboard bundle. The decoder (master) drives
//               the instruction fields and reads back the stall/issue/forward
//               controls; the scoreboard (slave) does the reverse.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int LAT_W  = 3
);
  logic              Issue_Valid_DEC;
  logic [REG_AW-1:0] Rs_DEC;
  logic [REG_AW-1:0] Rt_DEC;
  logic              UseRs_DEC;
  logic              UseRt_DEC;
  logic              RegWrite_DEC;
  logic [REG_AW-1:0] RegDst_DEC;
  logic [LAT_W-1:0]  Lat_DEC;
  logic              Flush;
  logic              PC_write;
  logic              IFID_write;
  logic              stall_IDEX;
  logic              Issue_Fire;
  logic              Busy;
  logic [REG_AW:0]   Pending_Count;
  logic              Fwd_Rs;
  logic              Fwd_Rt;

  modport master (
    output Issue_Valid_DEC, Rs_DEC, Rt_DEC, UseRs_DEC, UseRt_DEC,
           RegWrite_DEC, RegDst_DEC, Lat_DEC, Flush,
    input  PC_write, IFID_write, stall_IDEX, Issue_Fire, Busy,
           Pending_Count, Fwd_Rs, Fwd_Rt
  );

  modport slave (
    input  Issue_Valid_DEC, Rs_DEC, Rt_DEC, UseRs_DEC, UseRt_DEC,
           RegWrite_DEC, RegDst_DEC, Lat_DEC, Flush,
    output PC_write, IFID_write, stall_IDEX, Issue_Fire, Busy,
           Pending_Count, Fwd_Rs, Fwd_Rt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Per-register countdown scoreboard for the decode stage.
//               Each architectural register (except r0) carries a counter of
//               cycles until its pending writeback; RAW and WAW hazards stall
//               issue, Flush squashes the DEC instruction.
//               Optional macro HAZARD_FWD_EN lets a consumer issue in the
//               producer's writeback cycle, taking the operand off the WB bus.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NREGS  = 2**REG_AW,
  parameter int LAT_W  = 3
) (
  input  wire logic          Clk,
  input  wire logic          Rst_n,
  hazard_scoreboard_if.slave bus
);

`ifdef HAZARD_FWD_EN
  localparam logic [LAT_W-1:0] RAW_T = LAT_W'(1);
`else
  localparam logic [LAT_W-1:0] RAW_T = '0;
`endif

  logic [NREGS-1:0][LAT_W-1:0] cnt_q;
  logic [NREGS-1:0][LAT_W-1:0] cnt_d;

  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] cnt_rs;
  logic [LAT_W-1:0] cnt_rt;
  logic [LAT_W-1:0] cnt_dst;
  logic             raw_rs;
  logic             raw_rt;
  logic             waw;
  logic             valid;
  logic             stall;
  logic             fire;
  logic [REG_AW:0]  pending;

  // Hazard detection against the pre-issue counters of the DEC operands.
  always_comb begin
    lat_eff = (bus.Lat_DEC == '0) ? LAT_W'(1) : bus.Lat_DEC;
    cnt_rs  = cnt_q[bus.Rs_DEC];
    cnt_rt  = cnt_q[bus.Rt_DEC];
    cnt_dst = cnt_q[bus.RegDst_DEC];
    raw_rs  = bus.UseRs_DEC && (bus.Rs_DEC != '0) && (cnt_rs > RAW_T);
    raw_rt  = bus.UseRt_DEC && (bus.Rt_DEC != '0) && (cnt_rt > RAW_T);
    waw     = bus.RegWrite_DEC && (bus.RegDst_DEC != '0) && (cnt_dst > lat_eff);
    // Gating with Rst_n keeps every control at its idle value while reset is held.
    valid   = bus.Issue_Valid_DEC && Rst_n;
    stall   = valid && !bus.Flush && (raw_rs || raw_rt || waw);
    fire    = valid && !bus.Flush && !stall;
  end

  // Pipeline controls; Flush still advances PC and IF/ID but bubbles ID/EX.
  always_comb begin
    bus.PC_write   = !stall;
    bus.IFID_write = !stall;
    bus.stall_IDEX = Rst_n && (stall || bus.Flush);
    bus.Issue_Fire = fire;
  end

`ifdef HAZARD_FWD_EN
  // Operand whose producer writes back this cycle is taken from the WB bus.
  always_comb begin
    bus.Fwd_Rs = bus.UseRs_DEC && (bus.Rs_DEC != '0) && (cnt_rs == LAT_W'(1));
    bus.Fwd_Rt = bus.UseRt_DEC && (bus.Rt_DEC != '0) && (cnt_rt == LAT_W'(1));
  end
`else
  // Without forwarding the consumer always reads the register file.
  always_comb begin
    bus.Fwd_Rs = 1'b0;
    bus.Fwd_Rt = 1'b0;
  end
`endif

  // Next counters: decrement all live entries, then reload the issuing destination.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_W'(1)) : '0;
    end
    if (fire && bus.RegWrite_DEC && (bus.RegDst_DEC != '0)) begin
      cnt_d[bus.RegDst_DEC] = lat_eff;
    end
    // r0 is hard-wired and never tracked.
    cnt_d[0] = '0;
  end

  // Counter state; reset discards every pending writeback.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Occupancy straight from the current counters.
  always_comb begin
    pending = '0;
    for (int r = 1; r < NREGS; r++) begin
      pending = pending + (REG_AW+1)'(cnt_q[r] != '0);
    end
    bus.Pending_Count = pending;
    bus.Busy          = (pending != '0);
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the stall-only MIPS hazard unit.
- Replaces per-stage destination compares with a per-register countdown scoreboard, so variable-latency producers (ALU, load, multi-cycle mul/div) are tracked uniformly.
- Sits beside DEC and drives PC_write, IFID_write and the ID/EX bubble.
- Adds WAW protection, issue flush and an optional writeback-forwarding relaxation.

Parameters:
- REG_AW, 5, register address width.
- NREGS, 32, number of architectural registers (2**REG_AW); register 0 is never tracked.
- LAT_W, 3, latency counter width; max tracked latency = 2**LAT_W-1.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- Issue_Valid_DEC  in  1  valid instruction in DEC requesting issue.
- Rs_DEC  in  REG_AW  source register 1.
- Rt_DEC  in  REG_AW  source register 2.
- UseRs_DEC  in  1  instruction reads Rs.
- UseRt_DEC  in  1  instruction reads Rt.
- RegWrite_DEC  in  1  instruction writes a register.
- RegDst_DEC  in  REG_AW  destination register.
- Lat_DEC  in  LAT_W  cycles from issue until writeback cycle, inclusive.
- Flush  in  1  squash the DEC instruction this cycle (branch/jump redirect).
- PC_write  out  1  1 = PC may advance.
- IFID_write  out  1  1 = IF/ID may load.
- stall_IDEX  out  1  1 = insert bubble into ID/EX.
- Issue_Fire  out  1  DEC instruction issues this cycle.
- Busy  out  1  any register pending.
- Pending_Count  out  REG_AW+1  number of registers with a nonzero counter.
- Fwd_Rs  out  1  Rs taken from WB bus (HAZARD_FWD_EN only, else 0).
- Fwd_Rt  out  1  Rt taken from WB bus (HAZARD_FWD_EN only, else 0).

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..NREGS-1. cnt = 0 means ready; cnt = 1 means writeback occurs this cycle.
- Reset, asynchronous on Rst_n low: all cnt = 0.
  - Outputs while reset is held: PC_write = 1, IFID_write = 1, stall_IDEX = 0, Issue_Fire = 0, Busy = 0, Pending_Count = 0, Fwd_Rs = 0, Fwd_Rt = 0.
  - Reset mid-operation discards all pending state; no partial decrement.
- Effective latency: Lat_eff = (Lat_DEC == 0) ? 1 : Lat_DEC.
- RAW hazard: (UseRs_DEC && Rs_DEC != 0 && cnt[Rs_DEC] > T) || (UseRt_DEC && Rt_DEC != 0 && cnt[Rt_DEC] > T).
  - T = 0 normally; T = 1 under HAZARD_FWD_EN.
- WAW hazard: RegWrite_DEC && RegDst_DEC != 0 && cnt[RegDst_DEC] > Lat_eff.
  - Prevents a younger short-latency write completing before an older long-latency write.
- stall = Issue_Valid_DEC && !Flush && (RAW || WAW).
- Issue_Fire = Issue_Valid_DEC && !Flush && !stall.
- Combinational outputs, same cycle:
  - PC_write = !stall.
  - IFID_write = !stall.
  - stall_IDEX = stall || Flush.
  - Flush overrides stall: PC and IF/ID advance and a bubble enters ID/EX.
- Each rising edge: every nonzero cnt decrements by 1.
  - If Issue_Fire && RegWrite_DEC && RegDst_DEC != 0, cnt[RegDst_DEC] <= Lat_eff. This replaces that register's decrement.
  - Because of the WAW rule, a reload never shortens an older, longer pending write.
- Write to register 0 is never recorded. Reads of register 0 never stall.
- Same-register source and destination (e.g. add r3,r3,r1) is checked against the pre-issue counter only.
- Busy = OR of all cnt != 0. Pending_Count = popcount(cnt != 0). Both derive from current state, with no extra latency.
- Issue_Valid_DEC = 0: no stall, PC_write = 1, counters still decrement.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined:
  - T = 1; an operand whose producer writes back this cycle (cnt = 1) does not stall.
  - Fwd_Rs = UseRs_DEC && Rs_DEC != 0 && cnt[Rs_DEC] == 1; Fwd_Rt likewise.
  - DEC muxes the WB result in for those operands.
- Undefined:
  - T = 0; the consumer waits until cnt = 0 (value in register file).
  - Fwd_Rs and Fwd_Rt tied to 0.

Test Plan:
- Reset: hold Rst_n = 0 for 3 cycles with Issue_Valid_DEC = 1 -> PC_write = 1, stall_IDEX = 0, Busy = 0, Pending_Count = 0. Assert Rst_n mid-stall -> outputs return to reset values immediately.
- RAW on ALU result: issue RegDst = 8, Lat = 3, then a consumer with Rs = 8 -> stall_IDEX = 1 for 3 cycles (2 with HAZARD_FWD_EN, Fwd_Rs = 1 on the release cycle), then Issue_Fire = 1.
- WAW: issue RegDst = 5, Lat = 7, then RegDst = 5, Lat = 2 with no source use -> stalls 5 cycles until cnt[5] = 2, then issues; cnt[5] reloads to 2.
- Register 0: RegDst = 0, Lat = 7, then Rs = 0, Rt = 0 consumer -> no stall, Busy stays 0.
- Flush during stall: stall pending on r9 with Flush = 1 -> PC_write = 1, IFID_write = 1, stall_IDEX = 1, Issue_Fire = 0, cnt[9] keeps decrementing.
- Occupancy: issue 4 writes to r1..r4 with Lat = 7 on consecutive cycles -> Pending_Count = 1, 2, 3, 4, then falls to 0 after the last counter expires; Busy deasserts the same cycle.
